serial_tx8: RTL and testbench
=============================

SERIAL_TX8 -- requirements
Module: serial_tx8

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 1, meaning clock cycles per serial bit; legal range 1..255.
REQ-002 The block SHALL have port clc, input, 1, system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port R, input, 1, reset; asynchronous, active-high.
REQ-004 The block SHALL have port dIn, input, 8, parallel word to transmit.
REQ-005 The block SHALL have port start, input, 1, transmit request; sampled only while ready=1.
REQ-006 The block SHALL have port ready, output, 1, high when in IDLE and a request can be accepted.
REQ-007 The block SHALL have port sOut, output, 1, serial data, LSB first; connects to the receiving shift register's sIn.
REQ-008 The block SHALL have port shEn, output, 1, one-cycle strobe marking the clock edge on which the receiver must shift in sOut.
REQ-009 The block SHALL have port mode, output, 2, receiver mode: 2'b11 (serial shift-in) when shEn=1, else 2'b00 (hold).
REQ-010 The block SHALL have port busy, output, 1, high in SHIFT and DONE.
REQ-011 The block SHALL have port done, output, 1, one-cycle pulse after the eighth bit.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE.
- IDLE->SHIFT on start=1.
- SHIFT->DONE on the edge with shEn=1 and bitCnt=7.
- DONE->IDLE unconditionally after one cycle.
REQ-013 On an accepted start, the block SHALL load dIn into an 8-bit shift register sreg, clear bitCnt (3 bits) and divCnt (8 bits), and enter SHIFT on the same edge.
REQ-014 In SHIFT, sOut SHALL equal sreg[0]; in IDLE and DONE, sOut SHALL be 0.
REQ-015 divCnt SHALL count 0..CLKS_PER_BIT-1 in SHIFT, wrapping to 0; shEn SHALL be 1 exactly when in SHIFT and divCnt=CLKS_PER_BIT-1.
REQ-016 On each shEn edge, sreg SHALL shift right by one with 0 into bit 7, and bitCnt SHALL increment.
REQ-017 Each bit SHALL be held on sOut for exactly CLKS_PER_BIT cycles; with CLKS_PER_BIT=1, shEn SHALL be high every SHIFT cycle.
REQ-018 Frame latency SHALL be 8*CLKS_PER_BIT SHIFT cycles plus 1 DONE cycle; the first bit SHALL appear on the cycle after acceptance.
REQ-019 A receiver that shifts right with sIn entering at bit 7 on each shEn edge SHALL hold the transmitted word, bit-exact, at the done cycle.
REQ-020 ready SHALL be 1 only in IDLE; start and dIn SHALL be ignored in SHIFT and DONE, and dIn changes after acceptance SHALL NOT affect the frame.
REQ-021 start held high continuously SHALL produce back-to-back frames separated by exactly one DONE cycle and one IDLE cycle.

Reset
REQ-022 While R=1, the block SHALL be in IDLE with sreg=0, bitCnt=0, divCnt=0, sOut=0, shEn=0, mode=2'b00, busy=0, done=0 and ready=1, independent of clc.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately without a done pulse; after R deasserts, the next start SHALL begin a full new frame.

Verification
REQ-024 The bench SHALL cover, with CLKS_PER_BIT=1, dIn=8'hA5 and a one-cycle start: sOut cycles 1..8 = 1,0,1,0,0,1,0,1, shEn=1 and mode=2'b11 on cycles 1..8, done=1 on cycle 9, and an attached receiver in mode 11 reads Q=8'hA5.
REQ-025 The bench SHALL cover CLKS_PER_BIT=3 with dIn=8'h81: each bit held 3 cycles, shEn on cycles 3,6,...,24 only, done on cycle 25, and the receiver reads 8'h81.
REQ-026 The bench SHALL cover start pulsed and dIn changed to 8'hFF during a 8'h3C frame: the new request is ignored, ready=0 throughout, and the receiver reads 8'h3C.
REQ-027 The bench SHALL cover start held high with dIn=8'h0F: frames repeat with the pattern SHIFT x8, DONE, IDLE, SHIFT and a 10-cycle period.
REQ-028 The bench SHALL cover R asserted asynchronously after bit 4: all outputs reach reset values before the next clc edge, no done pulse occurs, and a subsequent 8'h5A frame completes correctly.

Source files
------------

// File: rtl/serial_tx8.sv
// 8-bit LSB-first serial transmitter driving a downstream shift register:
// per-bit strobe (shEn), receiver mode select, and a done pulse at frame end.
module serial_tx8 #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic       clc,
  input  logic       R,
  input  logic [7:0] dIn,
  input  logic       start,
  output logic       ready,
  output logic       sOut,
  output logic       shEn,
  output logic [1:0] mode,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLKS_PER_BIT - 1);

  state_t     r_state, w_state_next;
  logic [7:0] r_sreg, w_sreg_next;
  logic [2:0] r_bitCnt, w_bitCnt_next;
  logic [7:0] r_divCnt, w_divCnt_next;
  logic       w_shEn;

  always_ff @(posedge clc or posedge R) begin
    if (R) begin
      r_state  <= IDLE;
      r_sreg   <= '0;
      r_bitCnt <= '0;
      r_divCnt <= '0;
    end else begin
      r_state  <= w_state_next;
      r_sreg   <= w_sreg_next;
      r_bitCnt <= w_bitCnt_next;
      r_divCnt <= w_divCnt_next;
    end
  end

  // The strobe marks the last divider cycle of each bit; the receiver shifts on that edge.
  assign w_shEn = (r_state == SHIFT) && (r_divCnt == DIV_LAST);

  always_comb begin
    w_state_next  = r_state;
    w_sreg_next   = r_sreg;
    w_bitCnt_next = r_bitCnt;
    w_divCnt_next = r_divCnt;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next  = SHIFT;
          w_sreg_next   = dIn;
          w_bitCnt_next = '0;
          w_divCnt_next = '0;
        end
      end
      SHIFT: begin
        if (w_shEn) begin
          w_divCnt_next = '0;
          w_sreg_next   = {1'b0, r_sreg[7:1]};
          w_bitCnt_next = r_bitCnt + 3'd1;
          if (r_bitCnt == 3'd7) w_state_next = DONE;
        end else begin
          w_divCnt_next = r_divCnt + 8'd1;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign ready = (r_state == IDLE);
  assign busy  = (r_state == SHIFT) || (r_state == DONE);
  assign done  = (r_state == DONE);
  assign sOut  = (r_state == SHIFT) ? r_sreg[0] : 1'b0;
  assign shEn  = w_shEn;
  assign mode  = w_shEn ? 2'b11 : 2'b00;

endmodule

// File: tb/tb_serial_tx8.sv
// Directed bench for serial_tx8: one instance at 1 clock/bit, one at 3 clocks/bit,
// each feeding a behavioural receiver shift register.
module tb_serial_tx8;

  logic       clc = 1'b0;
  logic       R   = 1'b1;
  logic [7:0] din1 = '0, din3 = '0;
  logic       start1 = 1'b0, start3 = 1'b0;
  logic       ready1, sout1, shen1, busy1, done1;
  logic       ready3, sout3, shen3, busy3, done3;
  logic [1:0] mode1, mode3;
  logic [7:0] rxq1 = '0, rxq3 = '0;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clc = ~clc;

  serial_tx8 #(.CLKS_PER_BIT(1)) u_dut1 (
    .clc(clc), .R(R), .dIn(din1), .start(start1), .ready(ready1), .sOut(sout1),
    .shEn(shen1), .mode(mode1), .busy(busy1), .done(done1)
  );

  serial_tx8 #(.CLKS_PER_BIT(3)) u_dut3 (
    .clc(clc), .R(R), .dIn(din3), .start(start3), .ready(ready3), .sOut(sout3),
    .shEn(shen3), .mode(mode3), .busy(busy3), .done(done3)
  );

  // Receiving shift register: right shift, sIn into bit 7, on shEn edges.
  always @(posedge clc) begin
    if (shen1) rxq1 <= {sout1, rxq1[7:1]};
    if (shen3) rxq3 <= {sout3, rxq3[7:1]};
  end

  typedef struct {
    logic       sout;
    logic       shen;
    logic [1:0] mode;
    logic       done;
    logic       ready;
    logic       busy;
  } vec_t;

  vec_t tbl[1:10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle1(input string tag);
    chk({tag, "_sout"},  sout1,  0);
    chk({tag, "_shen"},  shen1,  0);
    chk({tag, "_mode"},  mode1,  0);
    chk({tag, "_busy"},  busy1,  0);
    chk({tag, "_done"},  done1,  0);
    chk({tag, "_ready"}, ready1, 1);
  endtask

  // Returns at the negedge of cycle 1 (first cycle after acceptance).
  task automatic launch1(input logic [7:0] d);
    @(negedge clc);
    din1 = d; start1 = 1'b1;
    @(negedge clc);
    start1 = 1'b0;
  endtask

  task automatic wait_ready1(input string tag);
    int unsigned k = 0;
    while (!ready1 && k < 40) begin
      @(negedge clc);
      k++;
    end
    chk({tag, "_ready_timeout"}, ready1, 1);
  endtask

  initial begin
    logic [7:0] w;
    int unsigned p;
    bit seen_done;

    tbl[1]  = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0};

    // Reset state before any clock edge.
    #1;
    chk_idle1("rst0");
    chk("rst0_ready3", ready3, 1);
    chk("rst0_busy3",  busy3,  0);
    chk("rst0_sout3",  sout3,  0);
    repeat (2) @(negedge clc);
    R = 1'b0;

    // A5 frame at 1 clock/bit, table-driven.
    launch1(8'hA5);
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) @(negedge clc);
      chk($sformatf("a5_sout_c%0d", c),  sout1,  tbl[c].sout);
      chk($sformatf("a5_shen_c%0d", c),  shen1,  tbl[c].shen);
      chk($sformatf("a5_mode_c%0d", c),  mode1,  tbl[c].mode);
      chk($sformatf("a5_done_c%0d", c),  done1,  tbl[c].done);
      chk($sformatf("a5_ready_c%0d", c), ready1, tbl[c].ready);
      chk($sformatf("a5_busy_c%0d", c),  busy1,  tbl[c].busy);
      if (c == 9) chk("a5_rx", rxq1, 8'hA5);
    end

    // 81 frame at 3 clocks/bit.
    w = 8'h81;
    @(negedge clc);
    din3 = w; start3 = 1'b1;
    @(negedge clc);
    start3 = 1'b0;
    for (int c = 1; c <= 26; c++) begin
      if (c > 1) @(negedge clc);
      chk($sformatf("c3_sout_c%0d", c), sout3, (c <= 24) ? w[(c-1)/3] : 1'b0);
      chk($sformatf("c3_shen_c%0d", c), shen3, (c <= 24) && (c % 3 == 0));
      chk($sformatf("c3_mode_c%0d", c), mode3, ((c <= 24) && (c % 3 == 0)) ? 2'b11 : 2'b00);
      chk($sformatf("c3_done_c%0d", c), done3, c == 25);
      chk($sformatf("c3_ready_c%0d", c), ready3, c == 26);
      if (c == 25) chk("c3_rx", rxq3, 8'h81);
    end

    // New request and dIn change mid-frame are ignored.
    launch1(8'h3C);
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) @(negedge clc);
      if (c <= 9) chk($sformatf("ign_ready_c%0d", c), ready1, 0);
      if (c == 3) begin din1 = 8'hFF; start1 = 1'b1; end
      if (c == 4) start1 = 1'b0;
      if (c == 9) begin
        chk("ign_done", done1, 1);
        chk("ign_rx",   rxq1,  8'h3C);
      end
      if (c == 10) chk_idle1("ign_after");
    end

    // Start held high: SHIFT x8, DONE, IDLE, repeat with a 10-cycle period.
    w = 8'h0F;
    @(negedge clc);
    din1 = w; start1 = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clc);
      p = (c - 1) % 10;
      chk($sformatf("b2b_ready_c%0d", c), ready1, p == 9);
      chk($sformatf("b2b_busy_c%0d", c),  busy1,  p != 9);
      chk($sformatf("b2b_done_c%0d", c),  done1,  p == 8);
      chk($sformatf("b2b_shen_c%0d", c),  shen1,  p < 8);
      chk($sformatf("b2b_sout_c%0d", c),  sout1,  (p < 8) ? w[p] : 1'b0);
      if (p == 8) chk($sformatf("b2b_rx_c%0d", c), rxq1, 8'h0F);
    end
    start1 = 1'b0;
    wait_ready1("b2b");

    // Asynchronous reset mid-frame, after bit 4 has been sent.
    launch1(8'hC3);
    repeat (4) @(negedge clc);
    chk("rst_mid_busy_before", busy1, 1);
    #2 R = 1'b1;
    #1;
    chk_idle1("rst_async");
    seen_done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clc);
      if (done1) seen_done = 1'b1;
    end
    chk("rst_no_done_held", seen_done, 0);
    R = 1'b0;
    @(negedge clc);
    chk_idle1("rst_released");

    w = 8'h5A;
    launch1(w);
    for (int c = 1; c <= 9; c++) begin
      if (c > 1) @(negedge clc);
      if (c <= 8) chk($sformatf("post_sout_c%0d", c), sout1, w[c-1]);
      chk($sformatf("post_done_c%0d", c), done1, c == 9);
      if (c == 9) chk("post_rx", rxq1, 8'h5A);
    end

    @(negedge clc);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
